register_file_mp: RTL

- Parametrised successor to the 16x16 two-read/one-write register file used by the CPU datapath.
- Data width and depth are generic.
- Adds an optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a sequential clear engine with a request/busy/done handshake and write back-pressure, so software or a controller can re-zero the file without asserting reset.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_ctrl.sv | 76 +++++++
 rtl/register_file_mp.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised multi-port register file.
package regfile_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultAddrWidth = 4;

  // Sweep-clear controller states
  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: walks every address once, writing zero, then pulses done.
// Holds write-ready low from the first sweep cycle through the done cycle.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear_req,
  output logic                  o_clear_busy,
  output logic                  o_clear_done,
  output logic                  o_write_ready,
  output logic [ADDR_WIDTH-1:0] o_clear_addr,
  output logic                  o_clear_we
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  rf_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ready;

  // FSM with registered busy/done/ready; requests outside IDLE are ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RF_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        RF_IDLE: begin
          if (i_clear_req) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        RF_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastAddr) begin
            r_state <= RF_DONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        RF_DONE: begin
          r_state <= RF_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= RF_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_clear_busy  = r_busy;
  assign o_clear_done  = r_done;
  assign o_write_ready = r_ready;
  assign o_clear_addr  = r_cnt;
  // Busy is high exactly in CLEAR, so it doubles as the array clear strobe
  assign o_clear_we    = r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Two-read/one-write register file with optional zero register, optional write-to-read
// bypass and a request/busy/done sweep clear that back-pressures writes.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned            ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned            ZERO_REG    = 0,
  parameter int unsigned            BYPASS      = 1,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_dest,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_write_ready,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [DATA_WIDTH-1:0] reg_read_data_1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [DATA_WIDTH-1:0] reg_read_data_2,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  logic                  w_clear_we;
  logic [ADDR_WIDTH-1:0] w_clear_addr;
  logic                  w_wr_acc;
  logic                  w_wr_do;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  regfile_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_ctrl (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_clear_req  (clear_req),
    .o_clear_busy (clear_busy),
    .o_clear_done (clear_done),
    .o_write_ready(reg_write_ready),
    .o_clear_addr (w_clear_addr),
    .o_clear_we   (w_clear_we)
  );

  assign w_wr_acc = reg_write_en & reg_write_ready;
  // Writes to register 0 are discarded entirely when it is hardwired
  assign w_wr_do  = w_wr_acc & ~((ZERO_REG != 0) && (reg_write_dest == '0));

  // Array update: sweep clear and port writes never coincide since ready is low while clearing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= RESET_VALUE;
      end
    end else if (w_clear_we) begin
      r_mem[w_clear_addr] <= '0;
    end else if (w_wr_do) begin
      r_mem[reg_write_dest] <= reg_write_data;
    end
  end

  // Read port 1: array, then optional bypass, then zero-register override
  always_comb begin
    w_rd1 = r_mem[reg_read_addr_1];
    if ((BYPASS != 0) && w_wr_do && (reg_read_addr_1 == reg_write_dest)) begin
      w_rd1 = reg_write_data;
    end
    if ((ZERO_REG != 0) && (reg_read_addr_1 == '0)) begin
      w_rd1 = '0;
    end
  end

  // Read port 2: same structure as port 1, fully independent
  always_comb begin
    w_rd2 = r_mem[reg_read_addr_2];
    if ((BYPASS != 0) && w_wr_do && (reg_read_addr_2 == reg_write_dest)) begin
      w_rd2 = reg_write_data;
    end
    if ((ZERO_REG != 0) && (reg_read_addr_2 == '0)) begin
      w_rd2 = '0;
    end
  end

  assign reg_read_data_1 = w_rd1;
  assign reg_read_data_2 = w_rd2;

endmodule
